instr_fetch_unit: RTL
=====================

# instr_fetch_unit

Instruction fetch stage of the KGP-RISC 32-bit pipeline. Owns the fetch PC, issues word requests to instruction memory over a req/ack handshake, and presents `pc` / `instruction_format` pairs to the decode stage that consumes them. Supports decode back-pressure through a one-entry skid buffer, and PC redirection from branch/jump resolution, which squashes wrong-path fetches.

## Interface

Parameters:
- `RESET_PC`, default 32'h0000_0000: first fetch address after reset.

Ports:
- `clk`  input  1: single clock, rising edge.
- `rst`  input  1: reset, synchronous, active-high.
- `redirect_valid`  input  1: taken branch/jump; load `redirect_pc` as the new fetch PC.
- `redirect_pc`  input  32: redirect target; bits [1:0] are ignored and treated as 0.
- `stall`  input  1: decode cannot accept this cycle.
- `imem_req`  output  1: instruction memory request.
- `imem_addr`  output  32: request address (current fetch PC).
- `imem_ack`  input  1: `imem_rdata` valid; sampled only while `imem_req` = 1.
- `imem_rdata`  input  32: fetched instruction word.
- `pc`  output  32: address of `instruction_format`.
- `instruction_format`  output  32: instruction word to decode.
- `instr_valid`  output  1: `pc` / `instruction_format` are valid.

## Operation

- State: `fetch_pc` (32 bits), output register (`pc`, `instruction_format`, `instr_valid`), skid register (pc + word), and an FSM with states IDLE, RUN, FULL and FLUSH.
- `imem_req` = 1 in RUN and FLUSH; otherwise 0. `imem_addr` = `fetch_pc`.
- Memory rule: once `imem_req` rises, `imem_req` and `imem_addr` hold stable until the edge at which `imem_ack` = 1. `imem_ack` may arrive in the same cycle as the request (zero wait).
- Decode consumption: an instruction is consumed at an edge where `instr_valid` = 1 and `stall` = 0. The output slot is free when `instr_valid` = 0 or `stall` = 0.
- IDLE: entered on reset. Goes to RUN unconditionally on the next cycle.
- RUN, `imem_ack` = 1, no redirect:
  - `fetch_pc` <= `fetch_pc` + 4. Wraps modulo 2^32, so 32'hFFFF_FFFC is followed by 0.
  - If the output slot is free: the output register loads {`fetch_pc`, `imem_rdata`}, `instr_valid` <= 1, and the FSM stays in RUN.
  - Otherwise: the skid register loads the pair and the FSM goes to FULL.
- RUN, no ack: if the output slot is free, `instr_valid` <= 0 (when consumed). Otherwise the output holds.
- FULL: `imem_req` = 0. When `stall` = 0, the output register loads from the skid register and the FSM goes to RUN. While `stall` = 1 the FSM stays in FULL.
- Redirect (`redirect_valid` = 1) has priority over `stall` and `imem_ack`. It clears `instr_valid` and the skid, and sets `fetch_pc` <= {`redirect_pc`[31:2], 2'b00}.
  - In RUN without ack, the request is still outstanding: go to FLUSH, keep `imem_addr` at the old address until ack, and latch the target in a pending register.
  - In RUN with ack, or in FULL or IDLE: discard any ack data and go to RUN with the new `fetch_pc`.
- FLUSH: on ack, discard the data, set `fetch_pc` <= the pending target, and go to RUN. A further redirect in FLUSH overwrites the pending target. `instr_valid` stays 0 throughout FLUSH.
- `rst` overrides everything, including a redirect or an ack in the same cycle.

## Timing

- Reset values:
  - outputs: `pc` = 0, `instruction_format` = 0, `instr_valid` = 0, `imem_req` = 0;
  - internal: `fetch_pc` = `RESET_PC`, skid empty, state IDLE.
- First `imem_req` is asserted one cycle after `rst` deasserts.
- Latency: ack edge to `instr_valid` = 1 is one cycle (registered outputs).
- Throughput: one instruction per cycle with zero-wait memory and `stall` = 0.
- Redirect to first new-path `instr_valid`: 2 cycles with zero-wait memory when no request is outstanding. When in FLUSH, add the remaining old-request latency.
- Ordering: instructions are never duplicated, dropped or reordered, except for intentional wrong-path squash on redirect.

## Test plan

1. Reset, `RESET_PC` = 0, zero-wait memory with rdata = addr ^ 32'hA5A5_0000, `stall` = 0 -> `imem_addr` runs 0, 4, 8, ...; `instr_valid` is continuous from the 3rd cycle after reset release; every `pc` / `instruction_format` pair matches.
2. Memory acks 3 cycles after req -> `imem_addr` is stable for 3 cycles; exactly one `instr_valid` cycle per ack; `pc` advances by 4 each time.
3. `stall` = 1 for 5 cycles with the instruction at 0x8 valid and the fetch of 0xC acked -> FSM enters FULL, `imem_req` = 0; after release, 0x8 then 0xC are presented in order and fetch resumes at 0x10.
4. Redirect to 32'h0000_0103 while the req for 0x20 is waiting on ack -> 0x20 data is discarded; the next `imem_addr` is 0x100; no `instr_valid` until 0x100 returns.
5. Redirect in the same cycle as an ack, and redirect in FULL -> both skid and output are cleared and the next fetch is the target; `fetch_pc` = 0xFFFF_FFFC followed by a normal fetch -> next addr is 0x0.
6. `rst` asserted mid-stream while FULL and with a FLUSH pending -> all outputs return to reset values next cycle, and fetching restarts at `RESET_PC`.

Source files
------------

// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : instr_fetch_unit
// Brief    : KGP-RISC fetch stage: PC, imem req/ack, one-entry skid, redirect.
// Revision : 1.0
// ============================================================================
module instr_fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   input  logic        stall,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic [31:0] pc,
   output logic [31:0] instruction_format,
   output logic        instr_valid
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      FULL  = 2'd2,
      FLUSH = 2'd3
   } state_t;

   state_t      state, state_n;
   logic [31:0] fetch_pc, fetch_pc_n;
   logic [31:0] pc_n, instr_n;
   logic        valid_n;
   logic [31:0] skid_pc, skid_pc_n, skid_word, skid_word_n;
   logic [31:0] pending_pc, pending_pc_n;
   logic [31:0] target;
   logic        ack;
   logic        slot_free;

   assign target    = {redirect_pc[31:2], 2'b00};
   assign imem_req  = (state == RUN) || (state == FLUSH);
   assign imem_addr = fetch_pc;
   assign ack       = imem_req && imem_ack;
   assign slot_free = !instr_valid || !stall;

   always_comb begin
      state_n      = state;
      fetch_pc_n   = fetch_pc;
      pc_n         = pc;
      instr_n      = instruction_format;
      valid_n      = instr_valid;
      skid_pc_n    = skid_pc;
      skid_word_n  = skid_word;
      pending_pc_n = pending_pc;

      case (state)
         IDLE: begin
            state_n = RUN;
            if (redirect_valid) begin
               fetch_pc_n = target;
            end
         end
         RUN: begin
            if (redirect_valid) begin
               valid_n     = 1'b0;
               skid_pc_n   = 32'd0;
               skid_word_n = 32'd0;
               if (ack) begin
                  fetch_pc_n = target;
               end else begin
                  // Old request still in flight: address must stay put until ack.
                  pending_pc_n = target;
                  state_n      = FLUSH;
               end
            end else if (ack) begin
               fetch_pc_n = fetch_pc + 32'd4;
               if (slot_free) begin
                  pc_n    = fetch_pc;
                  instr_n = imem_rdata;
                  valid_n = 1'b1;
               end else begin
                  skid_pc_n   = fetch_pc;
                  skid_word_n = imem_rdata;
                  state_n     = FULL;
               end
            end else if (slot_free) begin
               valid_n = 1'b0;
            end
         end
         FULL: begin
            if (redirect_valid) begin
               valid_n     = 1'b0;
               skid_pc_n   = 32'd0;
               skid_word_n = 32'd0;
               fetch_pc_n  = target;
               state_n     = RUN;
            end else if (!stall) begin
               pc_n    = skid_pc;
               instr_n = skid_word;
               valid_n = 1'b1;
               state_n = RUN;
            end
         end
         FLUSH: begin
            valid_n = 1'b0;
            if (ack) begin
               fetch_pc_n = redirect_valid ? target : pending_pc;
               state_n    = RUN;
            end else if (redirect_valid) begin
               pending_pc_n = target;
            end
         end
         default: begin
            state_n = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state              <= IDLE;
         fetch_pc           <= RESET_PC;
         pc                 <= 32'd0;
         instruction_format <= 32'd0;
         instr_valid        <= 1'b0;
         skid_pc            <= 32'd0;
         skid_word          <= 32'd0;
         pending_pc         <= 32'd0;
      end else begin
         state              <= state_n;
         fetch_pc           <= fetch_pc_n;
         pc                 <= pc_n;
         instruction_format <= instr_n;
         instr_valid        <= valid_n;
         skid_pc            <= skid_pc_n;
         skid_word          <= skid_word_n;
         pending_pc         <= pending_pc_n;
      end
   end

endmodule
`default_nettype wire
